cic_sample_packer: RTL and testbench



---
 rtl/cic_sample_packer.sv | 122 ++++++++++++
 tb/tb_cic_sample_packer.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/cic_sample_packer.sv
// Packs CIC decimator samples into 32-bit words, one or two samples per word.
// Words go through a small first-word-fall-through FIFO toward the uDMA RX channel.
module cic_sample_packer #(
    parameter int FIFO_DEPTH = 4,
    parameter int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             cfg_update_i,
    input  logic             cfg_pack_i,
    input  logic [15:0]      sample_i,
    input  logic             sample_valid_i,
    output logic [31:0]      data_o,
    output logic             data_valid_o,
    input  logic             data_ready_i,
    output logic             overflow_o,
    output logic [LVL_W-1:0] level_o
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    logic [31:0]      mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             half_vld_q, half_vld_d;
    logic [15:0]      half_q, half_d;
    logic             overflow_q, overflow_d;

    logic             push_req;
    logic [31:0]      push_word;
    logic             pop;
    logic             full;
    logic             push_ok;

    assign full         = (level_q == LVL_W'(FIFO_DEPTH));
    assign data_valid_o = (level_q != '0);
    assign pop          = data_valid_o & data_ready_i;
    assign push_ok      = push_req & (~full | pop);
    assign data_o       = data_valid_o ? mem_q[rd_ptr_q] : 32'h0;
    assign overflow_o   = overflow_q;
    assign level_o      = level_q;

    // In pack mode only the second sample of a pair produces a word; the earlier one sits low.
    always_comb begin
        push_req  = 1'b0;
        push_word = {{16{sample_i[15]}}, sample_i};
        if (sample_valid_i) begin
            if (!cfg_pack_i) begin
                push_req = 1'b1;
            end else if (half_vld_q) begin
                push_req  = 1'b1;
                push_word = {sample_i, half_q};
            end
        end
    end

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        half_vld_d = half_vld_q;
        half_d     = half_q;
        overflow_d = overflow_q;
        if (cfg_update_i) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            level_d    = '0;
            half_vld_d = 1'b0;
            overflow_d = 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({push_ok, pop})
                2'b10:   level_d = level_q + LVL_W'(1);
                2'b01:   level_d = level_q - LVL_W'(1);
                default: level_d = level_q;
            endcase
            if (push_req && !push_ok) begin
                overflow_d = 1'b1;
            end
            // A dropped packed word still consumes its half, keeping pairs aligned.
            if (sample_valid_i && cfg_pack_i) begin
                if (half_vld_q) begin
                    half_vld_d = 1'b0;
                end else begin
                    half_vld_d = 1'b1;
                    half_d     = sample_i;
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            half_vld_q <= 1'b0;
            half_q     <= 16'h0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            half_vld_q <= half_vld_d;
            half_q     <= half_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok && !cfg_update_i) begin
            mem_q[wr_ptr_q] <= push_word;
        end
    end

endmodule

// File: tb/tb_cic_sample_packer.sv
// Randomized and directed checks of cic_sample_packer against a queue-based reference model.
module tb_cic_sample_packer;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfgUpdate;
    logic        cfgPack;
    logic [15:0] sample;
    logic        sampleValid;
    logic        dataReady;
    logic [31:0] dataOut;
    logic        dataValid;
    logic        overflow;
    logic [2:0]  level;

    int compared   = 0;
    int mismatched = 0;

    // Reference model: the FIFO is a plain queue of words, plus the pending half sample.
    logic [31:0] refQ [$];
    bit          refHalfVld;
    logic [15:0] refHalf;
    bit          refOvf;

    cic_sample_packer #(.FIFO_DEPTH(DEPTH)) dut (
        .clk_i(clk),
        .rst_i(rst),
        .cfg_update_i(cfgUpdate),
        .cfg_pack_i(cfgPack),
        .sample_i(sample),
        .sample_valid_i(sampleValid),
        .data_o(dataOut),
        .data_valid_o(dataValid),
        .data_ready_i(dataReady),
        .overflow_o(overflow),
        .level_o(level)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic modelReset();
        refQ.delete();
        refHalfVld = 1'b0;
        refHalf    = 16'h0;
        refOvf     = 1'b0;
    endtask

    // Applies the word-formation, push, pop and flush rules to the queue for one clock edge.
    task automatic modelClock();
        bit          wantPush;
        bit          popNow;
        bit          wasFull;
        logic [31:0] word;
        if (rst || cfgUpdate) begin
            modelReset();
            return;
        end
        wantPush = 1'b0;
        word     = 32'h0;
        if (sampleValid) begin
            if (!cfgPack) begin
                wantPush = 1'b1;
                word     = {{16{sample[15]}}, sample};
            end else if (refHalfVld) begin
                wantPush   = 1'b1;
                word       = {sample, refHalf};
                refHalfVld = 1'b0;
            end else begin
                refHalf    = sample;
                refHalfVld = 1'b1;
            end
        end
        wasFull = (refQ.size() == DEPTH);
        popNow  = (refQ.size() != 0) && dataReady;
        if (popNow) void'(refQ.pop_front());
        if (wantPush) begin
            if (wasFull && !popNow) refOvf = 1'b1;
            else refQ.push_back(word);
        end
    endtask

    task automatic checkAll();
        checkOutput("valid", 32'(dataValid), 32'(refQ.size() != 0));
        checkOutput("level", 32'(level), 32'(refQ.size()));
        checkOutput("overflow", 32'(overflow), 32'(refOvf));
        if (refQ.size() != 0) checkOutput("data", dataOut, refQ[0]);
        else checkOutput("dataIdle", dataOut, 32'h0);
    endtask

    // Called at a falling edge: drive inputs, let one rising edge pass, check at the next falling edge.
    task automatic applyStimulus(input bit sv, input logic [15:0] s, input bit rdy, input bit upd);
        sampleValid = sv;
        sample      = s;
        dataReady   = rdy;
        cfgUpdate   = upd;
        @(posedge clk);
        modelClock();
        @(negedge clk);
        checkAll();
    endtask

    task automatic configure(input bit pack);
        cfgPack = pack;
        applyStimulus(1'b0, 16'h0, 1'b0, 1'b1);
    endtask

    initial begin
        rst         = 1'b1;
        cfgUpdate   = 1'b0;
        cfgPack     = 1'b0;
        sample      = 16'h0;
        sampleValid = 1'b0;
        dataReady   = 1'b0;
        modelReset();
        repeat (2) @(negedge clk);
        checkOutput("rstValid", 32'(dataValid), 32'h0);
        checkOutput("rstLevel", 32'(level), 32'h0);
        checkOutput("rstOverflow", 32'(overflow), 32'h0);
        rst = 1'b0;

        // Unpacked, ready held high.
        configure(1'b0);
        applyStimulus(1'b1, 16'h8001, 1'b1, 1'b0);
        checkOutput("unpackW0", dataOut, 32'hFFFF8001);
        applyStimulus(1'b1, 16'h7FFF, 1'b1, 1'b0);
        checkOutput("unpackW1", dataOut, 32'h00007FFF);
        checkOutput("unpackLvl", 32'(level), 32'h1);
        applyStimulus(1'b0, 16'h0, 1'b1, 1'b0);
        checkOutput("unpackEmpty", 32'(dataValid), 32'h0);

        // Packed pairs, ready held high.
        configure(1'b1);
        applyStimulus(1'b1, 16'h1111, 1'b1, 1'b0);
        checkOutput("packNoW1", 32'(dataValid), 32'h0);
        applyStimulus(1'b1, 16'h2222, 1'b1, 1'b0);
        checkOutput("packW0", dataOut, 32'h22221111);
        applyStimulus(1'b1, 16'h3333, 1'b1, 1'b0);
        checkOutput("packNoW3", 32'(dataValid), 32'h0);
        applyStimulus(1'b1, 16'h4444, 1'b1, 1'b0);
        checkOutput("packW1", dataOut, 32'h44443333);

        // Backpressure overflow: fifth word is dropped.
        configure(1'b0);
        for (int i = 1; i <= 5; i++) applyStimulus(1'b1, 16'(i), 1'b0, 1'b0);
        checkOutput("bpLevel", 32'(level), 32'h4);
        checkOutput("bpOverflow", 32'(overflow), 32'h1);
        for (int i = 1; i <= 4; i++) begin
            checkOutput("bpDrain", dataOut, 32'(i));
            applyStimulus(1'b0, 16'h0, 1'b1, 1'b0);
        end
        checkOutput("bpDrained", 32'(dataValid), 32'h0);
        checkOutput("bpOvfSticky", 32'(overflow), 32'h1);

        // Full with simultaneous pop and push.
        configure(1'b0);
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 16'h10 + 16'(i), 1'b0, 1'b0);
        applyStimulus(1'b1, 16'h14, 1'b1, 1'b0);
        checkOutput("fullPopLvl", 32'(level), 32'h4);
        checkOutput("fullPopOvf", 32'(overflow), 32'h0);
        for (int i = 1; i <= 4; i++) begin
            checkOutput("fullPopDrain", dataOut, 32'h10 + 32'(i));
            applyStimulus(1'b0, 16'h0, 1'b1, 1'b0);
        end

        // Flush with three words and a pending half.
        configure(1'b1);
        for (int i = 0; i < 7; i++) applyStimulus(1'b1, 16'h100 + 16'(i), 1'b0, 1'b0);
        checkOutput("flushPreLvl", 32'(level), 32'h3);
        applyStimulus(1'b1, 16'h5555, 1'b1, 1'b1);
        checkOutput("flushLvl", 32'(level), 32'h0);
        checkOutput("flushValid", 32'(dataValid), 32'h0);
        checkOutput("flushOvf", 32'(overflow), 32'h0);
        applyStimulus(1'b1, 16'hAAAA, 1'b0, 1'b0);
        applyStimulus(1'b1, 16'hBBBB, 1'b0, 1'b0);
        checkOutput("flushPair", dataOut, 32'hBBBBAAAA);

        // Asynchronous reset between edges.
        configure(1'b0);
        applyStimulus(1'b1, 16'h0021, 1'b0, 1'b0);
        applyStimulus(1'b1, 16'h0022, 1'b0, 1'b0);
        checkOutput("arPreLvl", 32'(level), 32'h2);
        #1 rst = 1'b1;
        #1;
        checkOutput("arValid", 32'(dataValid), 32'h0);
        checkOutput("arLevel", 32'(level), 32'h0);
        modelReset();
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(1'b1, 16'h0042, 1'b0, 1'b0);
        checkOutput("arFirst", dataOut, 32'h00000042);
        checkOutput("arOnly", 32'(level), 32'h1);

        // Randomized traffic, with occasional reconfiguration.
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 49) == 0) begin
                cfgPack = 1'($urandom);
                applyStimulus(1'($urandom), 16'($urandom), 1'($urandom), 1'b1);
            end else begin
                applyStimulus($urandom_range(0, 9) < 6, 16'($urandom),
                              $urandom_range(0, 9) < 4, 1'b0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
